led_panel_single_ctrl: RTL and testbench
========================================

Name:
led_panel_single_ctrl

Overview:
- Self-contained scan controller and test-pattern generator for one LED matrix panel that uses 1-bit RGB column data.
- Columns load through a serial shift chain (sclk/latch). Rows are selected by an external row-address shift register driven by aclk/arst.
- Generates a moving 3-bit colour pattern, with no pixel memory. Sits directly between the system clock and the panel connector pins.

Parameters:
- COLS, 32, columns shifted per row (power of two, 4..256).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- red_out  output  1  red column data bit.
- green_out  output  1  green column data bit.
- blue_out  output  1  blue column data bit.
- sclk_out  output  1  column shift clock; panel samples data on rising edge.
- latch_out  output  1  column latch strobe, 1-cycle high pulse.
- blank_out  output  1  output-enable inverse; 1 = panel dark.
- aclk_out  output  1  row-address shift clock, 1-cycle high pulse: advance to next row.
- arst_out  output  1  row-address reset, 1-cycle high pulse: select row 0.
- rowmax_in  input  3  panel height select; last row index = {rowmax_in,3'b111}, i.e. 8*(rowmax_in+1) rows.

Behaviour:
- All outputs are registered. Counters:
  - row: 6-bit.
  - frame: 8-bit, wraps.
  - col: log2(COLS) bits.
  - phase: 1 bit.
- Reset (async, any time, including mid-row):
  - red/green/blue/sclk/latch/aclk/arst = 0, blank_out = 1.
  - row = 0, frame = 0, state = SHIFT, col = 0, phase = 0.
  - The first cycle after reset release is SHIFT col 0 phase 0.
- Per-row sequence, 2*COLS+3 cycles; 67 cycles for COLS = 32.
- SHIFT, 2*COLS cycles, blank_out = 0:
  - Each column takes two cycles.
  - Phase 0: sclk_out = 0 and RGB = pixel(row, col).
  - Phase 1: sclk_out = 1 with RGB held.
  - col increments after phase 1. After col = COLS-1 phase 1, go to BLANK.
- BLANK, 1 cycle: blank_out = 1, sclk_out = 0, RGB = 0.
- LATCH, 1 cycle: blank_out = 1, latch_out = 1.
- ADDR, 1 cycle: blank_out = 1.
  - If row == 0: arst_out = 1, aclk_out = 0.
  - Otherwise: aclk_out = 1, arst_out = 0.
  - This brings the external address to match the row just latched.
  - At the end of ADDR:
    - If row >= {rowmax_in,3'b111}: row <- 0 and frame <- frame+1.
    - Otherwise: row <- row+1.
  - Return to SHIFT col 0.
- latch, aclk and arst are never high simultaneously. sclk is never high outside SHIFT phase 1.
- Pixel colour:
  - v = (col[2:0] + row[2:0] + frame[2:0]) mod 8.
  - red_out = v[0], green_out = v[1], blue_out = v[2].
- rowmax_in is sampled only in ADDR. A change mid-frame takes effect at the next ADDR.
  - If the current row already exceeds the new last row, the ">=" compare wraps at that ADDR.
- Frame length = 8*(rowmax_in+1)*(2*COLS+3) cycles. With rowmax_in = 0 and COLS = 32 this is 536 cycles.
- Per frame: exactly one arst pulse and 8*(rowmax_in+1)-1 aclk pulses.

Test Plan:
- Reset held then released, rowmax_in = 0:
  - During reset, blank_out = 1 and all other outputs = 0.
  - Cycle 0 after release: sclk = 0, blank = 0, RGB = 000.
- First row: count exactly 32 sclk rising edges in cycles 0..63.
  - RGB sampled at edge n gives v = n mod 8, e.g. edge 1 -> red = 1, edge 6 -> green = 1 and blue = 1.
- Row end: cycle 64 has blank = 1.
  - Cycle 65: latch = 1.
  - Cycle 66: arst = 1 and aclk = 0 (row 0).
  - Cycle 67: blank = 0, sclk = 0.
- Row 1: first sampled pixel v = 1 (red only). Its ADDR cycle (cycle 133) has aclk = 1 and arst = 0.
- Full frame, rowmax_in = 0:
  - 7 aclk pulses and 1 arst pulse in 536 cycles.
  - Frame 1, row 0, col 0 has v = 1.
  - Set rowmax_in = 1 -> frame becomes 16 rows / 1072 cycles with 15 aclk pulses.
- Assert reset in mid-SHIFT (e.g. cycle 300):
  - Outputs immediately return to reset values.
  - After release, the sequence restarts at row 0, frame 0 with arst at cycle 66.

Source files
------------

// File: rtl/led_panel_single_ctrl.sv
// Scan controller and moving test-pattern generator for one 1-bit-RGB LED matrix panel.
// Each row shifts COLS pixels, then blanks, latches and steps the external row address.
module led_panel_single_ctrl #(
  parameter int COLS = 32
) (
  input  logic       clk,
  input  logic       reset,
  output logic       red_out,
  output logic       green_out,
  output logic       blue_out,
  output logic       sclk_out,
  output logic       latch_out,
  output logic       blank_out,
  output logic       aclk_out,
  output logic       arst_out,
  input  logic [2:0] rowmax_in
);

  localparam int CW = $clog2(COLS);

  localparam logic [1:0] ST_SHIFT = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_ADDR  = 2'd3;

  logic [1:0]    state;
  logic [5:0]    row;
  logic [7:0]    frame;
  logic [CW-1:0] col;
  logic          phase;

  logic [2:0] col_lo;
  logic [2:0] pix;
  logic [5:0] last_row;

  always_comb begin
    col_lo   = 3'(col);
    pix      = col_lo + row[2:0] + frame[2:0];
    last_row = {rowmax_in, 3'b111};
  end

  // Outputs are registered from the current state, so the pins trail the
  // state registers by one clock; the first cycle after release is SHIFT col 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_SHIFT;
      row       <= '0;
      frame     <= '0;
      col       <= '0;
      phase     <= 1'b0;
      red_out   <= 1'b0;
      green_out <= 1'b0;
      blue_out  <= 1'b0;
      sclk_out  <= 1'b0;
      latch_out <= 1'b0;
      blank_out <= 1'b1;
      aclk_out  <= 1'b0;
      arst_out  <= 1'b0;
    end else begin
      red_out   <= 1'b0;
      green_out <= 1'b0;
      blue_out  <= 1'b0;
      sclk_out  <= 1'b0;
      latch_out <= 1'b0;
      blank_out <= 1'b1;
      aclk_out  <= 1'b0;
      arst_out  <= 1'b0;
      case (state)
        ST_SHIFT: begin
          blank_out                       <= 1'b0;
          sclk_out                        <= phase;
          {blue_out, green_out, red_out}  <= pix;
          phase                           <= ~phase;
          if (phase) begin
            // COLS is a power of two, so col wraps to 0 by itself.
            col <= col + 1'b1;
            if (col == CW'(COLS - 1)) state <= ST_BLANK;
          end
        end
        ST_BLANK: state <= ST_LATCH;
        ST_LATCH: begin
          latch_out <= 1'b1;
          state     <= ST_ADDR;
        end
        ST_ADDR: begin
          if (row == 6'd0) arst_out <= 1'b1;
          else             aclk_out <= 1'b1;
          if (row >= last_row) begin
            row   <= '0;
            frame <= frame + 8'd1;
          end else begin
            row <= row + 6'd1;
          end
          state <= ST_SHIFT;
        end
        default: state <= ST_SHIFT;
      endcase
    end
  end

endmodule

// File: tb/tb_led_panel_single_ctrl.sv
// Self-checking bench for led_panel_single_ctrl: directed vector table, multi-cycle
// sequences, and randomized rowmax/reset activity against a row-position reference model.
module tb_led_panel_single_ctrl;

  localparam int C = 32;
  localparam int ROW_LEN = 2 * C + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rowmax_in = 3'd0;
  logic       red_out, green_out, blue_out, sclk_out, latch_out, blank_out, aclk_out, arst_out;

  int checks = 0;
  int failures = 0;

  led_panel_single_ctrl #(.COLS(C)) dut (
    .clk      (clk),
    .reset    (reset),
    .red_out  (red_out),
    .green_out(green_out),
    .blue_out (blue_out),
    .sclk_out (sclk_out),
    .latch_out(latch_out),
    .blank_out(blank_out),
    .aclk_out (aclk_out),
    .arst_out (arst_out),
    .rowmax_in(rowmax_in)
  );

  always #5 clk = ~clk;

  // {blue, green, red, sclk, latch, blank, aclk, arst}
  logic [7:0] obs;
  assign obs = {blue_out, green_out, red_out, sclk_out, latch_out, blank_out, aclk_out, arst_out};

  localparam logic [7:0] RESET_OUT = 8'b0000_0100;

  typedef struct {
    int         cyc;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across an edge, checks the reset outputs, releases on a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check8("reset_state", obs, RESET_OUT);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Expected pins for position p within a row of the given row/frame.
  function automatic logic [7:0] model_out(input int r, input int f, input int p);
    logic [2:0] v;
    if (p < 2 * C) begin
      v = 3'((p / 2 + r + f) % 8);
      return {v, (p % 2 == 1), 4'b0000};
    end else if (p == 2 * C)     return 8'b0000_0100;
    else if (p == 2 * C + 1)     return 8'b0000_1100;
    else if (r == 0)             return 8'b0000_0101;
    else                         return 8'b0000_0110;
  endfunction

  initial begin
    int n_sclk, n_aclk, n_arst;
    int m_row, m_frame, m_pos;

    tbl.push_back('{0,   8'b0000_0000, "c0_shift_start"});
    tbl.push_back('{1,   8'b0001_0000, "c1_edge0"});
    tbl.push_back('{3,   8'b0011_0000, "c3_edge1_red"});
    tbl.push_back('{13,  8'b1101_0000, "c13_edge6_gb"});
    tbl.push_back('{62,  8'b1110_0000, "c62_col31_p0"});
    tbl.push_back('{63,  8'b1111_0000, "c63_col31_p1"});
    tbl.push_back('{64,  8'b0000_0100, "c64_blank"});
    tbl.push_back('{65,  8'b0000_1100, "c65_latch"});
    tbl.push_back('{66,  8'b0000_0101, "c66_arst"});
    tbl.push_back('{67,  8'b0010_0000, "c67_row1_start"});
    tbl.push_back('{68,  8'b0011_0000, "c68_row1_edge0"});
    tbl.push_back('{133, 8'b0000_0110, "c133_aclk"});
    tbl.push_back('{535, 8'b0000_0110, "c535_row7_aclk"});
    tbl.push_back('{536, 8'b0010_0000, "c536_frame1"});
    tbl.push_back('{602, 8'b0000_0101, "c602_frame1_arst"});

    // Directed table, rowmax 0
    rowmax_in = 3'd0;
    do_reset();
    n_sclk = 0; n_aclk = 0; n_arst = 0;
    for (int k = 0; k < 700; k++) begin
      step();
      foreach (tbl[i]) if (tbl[i].cyc == k) check8(tbl[i].name, obs, tbl[i].exp);
      if (k < 64 && sclk_out) n_sclk++;
      if (k < 536) begin
        if (aclk_out) n_aclk++;
        if (arst_out) n_arst++;
      end
    end
    check_int("row0_sclk_edges", n_sclk, 32);
    check_int("frame_aclk_rm0", n_aclk, 7);
    check_int("frame_arst_rm0", n_arst, 1);

    // 16-row frame
    rowmax_in = 3'd1;
    do_reset();
    n_aclk = 0; n_arst = 0;
    for (int k = 0; k < 1139; k++) begin
      step();
      if (k < 1072) begin
        if (aclk_out) n_aclk++;
        if (arst_out) n_arst++;
      end
      if (k == 602)  check8("rm1_row8_aclk", obs, 8'b0000_0110);
      if (k == 1138) check8("rm1_frame1_arst", obs, 8'b0000_0101);
    end
    check_int("frame_aclk_rm1", n_aclk, 15);
    check_int("frame_arst_rm1", n_arst, 1);

    // Reset asserted mid-SHIFT
    rowmax_in = 3'd0;
    do_reset();
    for (int k = 0; k <= 300; k++) step();
    #2 reset = 1'b1;
    #1 check8("midrow_reset_async", obs, RESET_OUT);
    @(negedge clk);
    reset = 1'b0;
    n_aclk = 0; n_arst = 0;
    for (int k = 0; k <= 66; k++) begin
      step();
      if (k == 0)  check8("restart_c0", obs, 8'b0000_0000);
      if (k == 66) check8("restart_c66_arst", obs, 8'b0000_0101);
      if (aclk_out) n_aclk++;
      if (arst_out) n_arst++;
    end
    check_int("restart_aclk_count", n_aclk, 0);
    check_int("restart_arst_count", n_arst, 1);

    // Randomized rowmax changes and resets against the reference model
    rowmax_in = 3'($urandom_range(0, 7));
    do_reset();
    m_row = 0; m_frame = 0; m_pos = 0;
    for (int k = 0; k < 8000; k++) begin
      step();
      check8("rand_cycle", obs, model_out(m_row, m_frame % 256, m_pos));
      if ($urandom_range(0, 1999) == 0) begin
        #2 reset = 1'b1;
        #1 check8("rand_reset_async", obs, RESET_OUT);
        @(negedge clk);
        reset = 1'b0;
        m_row = 0; m_frame = 0; m_pos = 0;
      end else begin
        if (m_pos == ROW_LEN - 1) begin
          m_pos = 0;
          if (m_row >= 8 * int'(rowmax_in) + 7) begin
            m_row = 0;
            m_frame++;
          end else begin
            m_row++;
          end
        end else begin
          m_pos++;
        end
        if ($urandom_range(0, 299) == 0) rowmax_in = 3'($urandom_range(0, 7));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
